// File: rtl/pipe_frame_painter_if.sv
// rtl/pipe_frame_painter_if.sv - game-state and VGA pixel bus for the frame painter
interface pipe_frame_painter_if #(
    parameter int NUM_PIPES = 2
);
    logic                     game_pulse;
    logic [6:0]               box_y;
    logic [8*NUM_PIPES-1:0]   pipe_x;
    logic [7*NUM_PIPES-1:0]   pipe_gap_y;
    logic                     plot;
    logic [7:0]               x;
    logic [6:0]               y;
    logic [2:0]               colour;
    logic                     game_tick_after_erase;
    logic                     busy;

    modport master (
        input  game_pulse, box_y, pipe_x, pipe_gap_y,
        output plot, x, y, colour, game_tick_after_erase, busy
    );

    modport slave (
        output game_pulse, box_y, pipe_x, pipe_gap_y,
        input  plot, x, y, colour, game_tick_after_erase, busy
    );
endinterface

// File: rtl/pipe_frame_painter.sv
// rtl/pipe_frame_painter.sv - draws/erases pipes and player box into a 160x120 frame buffer
module pipe_frame_painter #(
    parameter int NUM_PIPES  = 2,
    parameter int PIPE_WIDTH = 4,
    parameter int GAP_HEIGHT = 30,
    parameter int BOX_SIZE   = 3,
    parameter int BOX_X      = 4,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    pipe_frame_painter_if.master  bus
);
    localparam int IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    localparam int SLOTS = 1 << IDX_W;

    localparam logic [2:0] C_PIPE  = 3'b010;
    localparam logic [2:0] C_BOX   = 3'b110;
    localparam logic [2:0] C_ERASE = 3'b000;

    typedef enum logic [3:0] {
        INIT, LATCH, DRAW_PIPE, DRAW_BOX, WAIT_PULSE,
        ERASE_PIPE, ERASE_BOX, TOGGLE, SETTLE
    } state_t;

    state_t            state_q;
    logic              pend_q;
    logic [6:0]        by_q;
    logic [7:0]        px_q [SLOTS];
    logic [6:0]        gy_q [SLOTS];
    logic [IDX_W-1:0]  idx_q;
    logic [3:0]        col_q;
    logic [6:0]        row_q;
    logic              settle_q;
    logic              plot_q;
    logic [7:0]        x_q;
    logic [6:0]        y_q;
    logic [2:0]        colour_q;
    logic              tick_q;

    logic [7:0] cur_px_d;
    logic [6:0] cur_gy_d;
    logic [8:0] pipe_col_d;
    logic [7:0] gap_end_d;
    logic       in_gap_d;
    logic       pipe_on_d;
    logic [7:0] box_row_d;
    logic [7:0] box_col_d;
    logic       box_on_d;
    logic       erasing_d;
    logic       last_row_d;
    logic       last_col_d;
    logic       last_pipe_d;
    logic       box_last_col_d;
    logic       box_last_row_d;

    // Column sum is 9 bits so pipes near the right edge clip instead of wrapping.
    assign cur_px_d       = px_q[idx_q];
    assign cur_gy_d       = gy_q[idx_q];
    assign pipe_col_d     = {1'b0, cur_px_d} + {5'b0, col_q};
    assign gap_end_d      = {1'b0, cur_gy_d} + 8'(GAP_HEIGHT - 1);
    assign in_gap_d       = (row_q >= cur_gy_d) && ({1'b0, row_q} <= gap_end_d);
    assign pipe_on_d      = pipe_col_d < 9'(SCREEN_W);
    assign box_row_d      = {1'b0, by_q} + {1'b0, row_q};
    assign box_col_d      = 8'(BOX_X) + {4'b0, col_q};
    assign box_on_d       = box_row_d < 8'(SCREEN_H);
    assign erasing_d      = (state_q == ERASE_PIPE) || (state_q == ERASE_BOX);
    assign last_row_d     = row_q == 7'(SCREEN_H - 1);
    assign last_col_d     = col_q == 4'(PIPE_WIDTH - 1);
    assign last_pipe_d    = idx_q == IDX_W'(NUM_PIPES - 1);
    assign box_last_col_d = col_q == 4'(BOX_SIZE - 1);
    assign box_last_row_d = row_q == 7'(BOX_SIZE - 1);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= INIT;
            pend_q   <= 1'b0;
            by_q     <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                px_q[i] <= '0;
                gy_q[i] <= '0;
            end
            idx_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            settle_q <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= C_ERASE;
            tick_q   <= 1'b0;
        end else begin
            // The WAIT_PULSE exit consumes the pending tick and any pulse arriving with it.
            if (state_q == WAIT_PULSE && pend_q)
                pend_q <= 1'b0;
            else
                pend_q <= pend_q | bus.game_pulse;

            plot_q <= 1'b0;

            case (state_q)
                INIT: state_q <= LATCH;

                LATCH: begin
                    by_q <= bus.box_y;
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        px_q[i] <= bus.pipe_x[8*i +: 8];
                        gy_q[i] <= bus.pipe_gap_y[7*i +: 7];
                    end
                    idx_q   <= '0;
                    col_q   <= '0;
                    row_q   <= '0;
                    state_q <= DRAW_PIPE;
                end

                DRAW_PIPE, ERASE_PIPE: begin
                    plot_q   <= pipe_on_d && (erasing_d || !in_gap_d);
                    if (pipe_on_d)
                        x_q <= pipe_col_d[7:0];
                    y_q      <= row_q;
                    colour_q <= erasing_d ? C_ERASE : C_PIPE;
                    if (last_row_d) begin
                        row_q <= '0;
                        if (last_col_d) begin
                            col_q <= '0;
                            if (last_pipe_d) begin
                                idx_q   <= '0;
                                state_q <= erasing_d ? ERASE_BOX : DRAW_BOX;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end

                DRAW_BOX, ERASE_BOX: begin
                    plot_q   <= box_on_d;
                    x_q      <= box_col_d;
                    if (box_on_d)
                        y_q <= box_row_d[6:0];
                    colour_q <= erasing_d ? C_ERASE : C_BOX;
                    if (box_last_col_d) begin
                        col_q <= '0;
                        if (box_last_row_d) begin
                            row_q   <= '0;
                            state_q <= erasing_d ? TOGGLE : WAIT_PULSE;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end

                WAIT_PULSE: begin
                    if (pend_q)
                        state_q <= ERASE_PIPE;
                end

                TOGGLE: begin
                    tick_q   <= ~tick_q;
                    settle_q <= 1'b0;
                    state_q  <= SETTLE;
                end

                SETTLE: begin
                    if (settle_q)
                        state_q <= LATCH;
                    else
                        settle_q <= 1'b1;
                end

                default: state_q <= INIT;
            endcase
        end
    end

    assign bus.plot                  = plot_q;
    assign bus.x                     = x_q;
    assign bus.y                     = y_q;
    assign bus.colour                = colour_q;
    assign bus.game_tick_after_erase = tick_q;
    assign bus.busy                  = (state_q != WAIT_PULSE);
endmodule

// File: tb/tb_pipe_frame_painter.sv
// tb/tb_pipe_frame_painter.sv - directed bench for pipe_frame_painter
module tb_pipe_frame_painter;
    logic clk = 1'b0;
    logic reset;

    pipe_frame_painter_if #(.NUM_PIPES(2)) bus ();

    pipe_frame_painter #(
        .NUM_PIPES(2), .PIPE_WIDTH(4), .GAP_HEIGHT(30), .BOX_SIZE(3),
        .BOX_X(4), .SCREEN_W(160), .SCREEN_H(120)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycles, n_plot, n_c010, n_c110, n_c000, n_xover, win_a, win_b;
    int ax_lo, ax_hi, ay_lo, ay_hi, bx_lo, bx_hi, by_lo, by_hi;
    int lat, toggles, found;
    logic prev_tick;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_windows(input int a0, input int a1, input int a2, input int a3,
                               input int b0, input int b1, input int b2, input int b3);
        ax_lo = a0; ax_hi = a1; ay_lo = a2; ay_hi = a3;
        bx_lo = b0; bx_hi = b1; by_lo = b2; by_hi = b3;
    endtask

    task automatic clear_stats();
        cycles = 0; n_plot = 0; n_c010 = 0; n_c110 = 0; n_c000 = 0;
        n_xover = 0; win_a = 0; win_b = 0;
    endtask

    task automatic sample_stats();
        int px, py;
        px = int'(bus.x);
        py = int'(bus.y);
        if (px > 159) n_xover++;
        if (bus.plot === 1'b1) begin
            n_plot++;
            if (bus.colour === 3'b010) n_c010++;
            if (bus.colour === 3'b110) n_c110++;
            if (bus.colour === 3'b000) n_c000++;
            if (px >= ax_lo && px <= ax_hi && py >= ay_lo && py <= ay_hi) win_a++;
            if (px >= bx_lo && px <= bx_hi && py >= by_lo && py <= by_hi) win_b++;
        end
    endtask

    // Counts negedges with busy high; a timeout leaves cycles at -1.
    task automatic scan_until_idle(input int bound, input bit pulses);
        clear_stats();
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            bus.game_pulse = pulses && (cycles == 100 || cycles == 200 || cycles == 300);
            sample_stats();
            if (bus.busy !== 1'b1) begin
                bus.game_pulse = 1'b0;
                return;
            end
            cycles++;
        end
        bus.game_pulse = 1'b0;
        cycles = -1;
    endtask

    initial begin
        reset          = 1'b1;
        bus.game_pulse = 1'b0;
        bus.pipe_x     = {8'd80, 8'd20};
        bus.pipe_gap_y = {7'd50, 7'd40};
        bus.box_y      = 7'd60;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_plot",   int'(bus.plot), 0);
        check("reset_x",      int'(bus.x), 0);
        check("reset_y",      int'(bus.y), 0);
        check("reset_colour", int'(bus.colour), 0);
        check("reset_tick",   int'(bus.game_tick_after_erase), 0);
        check("reset_busy",   int'(bus.busy), 1);

        // First draw: pipes at 20/80, gaps 40/50, box at row 60
        set_windows(20, 23, 40, 69, 4, 6, 60, 62);
        reset = 1'b0;
        scan_until_idle(3000, 1'b0);
        check("draw1_busy_cycles", cycles, 970);
        check("draw1_plots",       n_plot, 729);
        check("draw1_pipe_colour", n_c010, 720);
        check("draw1_box_colour",  n_c110, 9);
        check("draw1_gap_plots",   win_a, 0);
        check("draw1_box_pixels",  win_b, 9);
        check("draw1_x_over",      n_xover, 0);
        check("draw1_tick",        int'(bus.game_tick_after_erase), 0);

        repeat (5) @(negedge clk);
        check("idle_busy", int'(bus.busy), 0);

        // Pulse in WAIT_PULSE; inputs changed afterwards must not affect the erase
        bus.game_pulse = 1'b1;
        @(negedge clk);
        bus.game_pulse = 1'b0;
        bus.pipe_x     = {8'd158, 8'd30};
        bus.pipe_gap_y = {7'd100, 7'd10};
        bus.box_y      = 7'd118;
        set_windows(20, 23, 40, 69, 0, 0, 0, 0);
        clear_stats();
        lat = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            lat++;
            sample_stats();
            if (bus.game_tick_after_erase === 1'b1) break;
        end
        check("pulse_to_toggle",  lat, 971);
        check("erase_plots",      n_plot, 969);
        check("erase_black",      n_c000, 969);
        check("erase_gap_pixels", win_a, 120);

        // Redraw with the clipped pipe and low box; three pulses land mid-draw
        set_windows(158, 159, 100, 119, 158, 159, 0, 99);
        scan_until_idle(3000, 1'b1);
        check("draw2_busy_cycles", cycles, 971);
        check("draw2_plots",       n_plot, 566);
        check("draw2_pipe_colour", n_c010, 560);
        check("draw2_box_colour",  n_c110, 6);
        check("draw2_gap_bottom",  win_a, 0);
        check("draw2_edge_cols",   win_b, 200);
        check("draw2_x_over",      n_xover, 0);

        // Coalesced pulses give one cycle; a pulse during that erase gives one more
        toggles = 0;
        prev_tick = bus.game_tick_after_erase;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            bus.game_pulse = (i == 500);
            if (bus.game_tick_after_erase !== prev_tick) toggles++;
            prev_tick = bus.game_tick_after_erase;
        end
        bus.game_pulse = 1'b0;
        check("coalesce_toggles", toggles, 2);
        check("coalesce_idle",    int'(bus.busy), 0);

        // Reset in the middle of DRAW_PIPE
        bus.pipe_x     = {8'd80, 8'd20};
        bus.pipe_gap_y = {7'd50, 7'd40};
        bus.box_y      = 7'd60;
        bus.game_pulse = 1'b1;
        @(negedge clk);
        bus.game_pulse = 1'b0;
        found = 0;
        prev_tick = bus.game_tick_after_erase;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.game_tick_after_erase !== prev_tick) begin
                found = 1;
                break;
            end
        end
        check("mid_toggle_seen", found, 1);
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.plot === 1'b1 && bus.x === 8'd80) begin
                found = 1;
                break;
            end
        end
        check("mid_pipe1_seen", found, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_plot",   int'(bus.plot), 0);
        check("midrst_x",      int'(bus.x), 0);
        check("midrst_y",      int'(bus.y), 0);
        check("midrst_colour", int'(bus.colour), 0);
        check("midrst_busy",   int'(bus.busy), 1);
        reset = 1'b0;
        set_windows(20, 23, 40, 69, 4, 6, 60, 62);
        scan_until_idle(3000, 1'b0);
        check("draw3_busy_cycles", cycles, 970);
        check("draw3_plots",       n_plot, 729);
        check("draw3_gap_plots",   win_a, 0);
        check("draw3_box_pixels",  win_b, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_frame_painter.md
# pipe_frame_painter

Parametrised successor to the single-pipe line painter. It draws NUM_PIPES pipes, each PIPE_WIDTH columns wide with a GAP_HEIGHT opening, plus the player box, into the 160x120 3-bit VGA frame buffer at one pixel per cycle. On each game tick it erases the previous frame's objects, toggles a handshake so the game logic can advance positions, then redraws from the new positions. It sits between the game-state logic and the VGA adapter's plot/x/y/colour inputs.

## Interface
- NUM_PIPES, 2, number of pipes drawn (1..4)
- PIPE_WIDTH, 4, pipe width in columns (1..8)
- GAP_HEIGHT, 30, vertical opening height in rows
- BOX_SIZE, 3, player box edge length in pixels
- BOX_X, 4, left column of player box
- SCREEN_W, 160 / SCREEN_H, 120, visible area
- CLOCK_50  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- game_pulse  in  1  one-cycle game tick request
- box_y  in  7  top row of player box
- pipe_x  in  8*NUM_PIPES  pipe i left column at [8i+7:8i]
- pipe_gap_y  in  7*NUM_PIPES  pipe i gap top row at [7i+6:7i]
- plot  out  1  write enable to VGA adapter
- x  out  8  pixel column
- y  out  7  pixel row
- colour  out  3  pixel colour: pipe 010, box 110, erase 000
- game_tick_after_erase  out  1  toggles once per completed erase
- busy  out  1  high in every state except WAIT_PULSE

## Operation
- States: INIT, LATCH, DRAW_PIPE, DRAW_BOX, WAIT_PULSE, ERASE_PIPE, ERASE_BOX, TOGGLE, SETTLE.
- INIT (after reset) -> LATCH. LATCH: snapshot box_y, pipe_x, pipe_gap_y into internal registers; clear pipe index and scan counters; -> DRAW_PIPE.
- DRAW_PIPE: scan pipe i column-major, column c = 0..PIPE_WIDTH-1, row r = 0..SCREEN_H-1. x = px+c, y = r, colour 010. plot = 1 unless r in [gy, gy+GAP_HEIGHT-1] or px+c >= SCREEN_W (9-bit sum, no wrap). After last pixel of pipe NUM_PIPES-1 -> DRAW_BOX.
- DRAW_BOX: BOX_SIZE x BOX_SIZE pixels, row-major from (BOX_X, by); colour 110; plot suppressed where by+r >= SCREEN_H. -> WAIT_PULSE.
- WAIT_PULSE: plot = 0; on pending tick -> ERASE_PIPE.
- ERASE_PIPE / ERASE_BOX: same scans using the latched snapshot, colour 000, plot = 1 for every in-screen pixel (gap rows included). -> TOGGLE.
- TOGGLE: invert game_tick_after_erase; -> SETTLE. SETTLE: 2 cycles, plot = 0, lets game logic update inputs; -> LATCH.
- game_pulse arriving in any state sets a single pending flag; cleared on WAIT_PULSE -> ERASE_PIPE. Multiple pulses while busy coalesce to one. Pulse in the same cycle as exit from WAIT_PULSE is absorbed by that exit.
- Gap range end computed 8-bit; gap extending past row 119 simply removes the bottom of the pipe.

## Timing
- Reset values: plot 0, x 0, y 0, colour 000, game_tick_after_erase 0, busy 1, pending 0, state INIT.
- Reset mid-scan: next cycle plot = 0, state INIT; no partial erase is attempted.
- plot/x/y/colour are registered and mutually consistent in the same cycle; one pixel per cycle, no stalls.
- Draw phase length: NUM_PIPES*PIPE_WIDTH*SCREEN_H + BOX_SIZE^2 cycles (defaults: 960 + 9 = 969). Erase phase identical length.
- Pulse to toggle latency from WAIT_PULSE: 1 + erase length + 1 cycles (defaults 971); redraw starts 3 cycles after toggle (SETTLE 2 + LATCH 1).
- Inputs are sampled only in LATCH; changes at other times have no effect.

## Test plan
- Reset, pipe_x={80,20}, pipe_gap_y={50,40}, box_y=60: draw phase emits 969 scan cycles; pipe0 plot=0 for y 40..69 at x 20..23; box pixels (4..6, 60..62) colour 110; busy falls after draw.
- game_pulse in WAIT_PULSE: erase of all previous pixels with colour 000, game_tick_after_erase toggles 0->1 after 971 cycles, redraw uses inputs present at LATCH.
- pipe_x=158, PIPE_WIDTH=4: columns 158,159 plotted; 160,161 plot=0; x never exceeds 159.
- box_y=118, gap_y=100: box rows 118,119 only; pipe rows 100..119 blank, no wrap to row 0.
- Three game_pulses during draw: exactly one erase/toggle; pulse during erase then yields one further cycle.
- Assert reset halfway through DRAW_PIPE: plot=0 next cycle, outputs at reset values, full redraw follows.
